// File: rtl/mcd_pkg.sv
// Shared definitions for the multi-channel counter display: glyph encoding,
// channel mode constants and the clock-cycle derivations for timing parameters.
package mcd_pkg;

    localparam bit MODE_HEX = 1'b0;
    localparam bit MODE_DEC = 1'b1;

    function automatic int calc_digit_cyc(input int clk_per, input int refr_rate);
        longint cyc;
        cyc = 64'sd1_000_000_000 / (longint'(clk_per) * longint'(refr_rate));
        return (cyc < 64'sd1) ? 32'sd1 : int'(cyc);
    endfunction

    function automatic int calc_dwell_cyc(input int dwell_us, input int clk_per);
        longint cyc;
        cyc = (longint'(dwell_us) * 64'sd1000) / longint'(clk_per);
        return (cyc < 64'sd1) ? 32'sd1 : int'(cyc);
    endfunction

    // Active-low cathodes, [6:0] = {g,f,e,d,c,b,a}, [7] = decimal point
    function automatic logic [7:0] seg_encode(input logic [3:0] nibble, input logic dp);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return {~dp, seg};
    endfunction

endpackage

// File: rtl/mcd_channel.sv
// One press counter channel: ND nibbles counting in HEX or BCD, with a
// one-cycle wrap pulse when the whole value rolls over.
module mcd_channel
    import mcd_pkg::*;
#(
    parameter int ND     = 3,
    parameter bit IS_DEC = MODE_HEX
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          inc,
    input  logic          dec,
    input  logic          clr,
    output logic [4*ND-1:0] digits,
    output logic          wrap
);

    localparam logic [3:0] LIM = IS_DEC ? 4'd9 : 4'd15;

    logic [4*ND-1:0] digits_r;
    logic [4*ND-1:0] next_s;
    logic            carry_s;
    logic [3:0]      nib_s;
    logic            wrap_r;

    // Digit-wise ripple increment/decrement; carry out of the top digit is a wrap
    always_comb begin
        next_s  = digits_r;
        carry_s = 1'b1;
        nib_s   = 4'd0;
        for (int i = 0; i < ND; i++) begin
            nib_s = digits_r[4*i +: 4];
            if (carry_s && inc) begin
                if (nib_s == LIM) begin
                    next_s[4*i +: 4] = 4'd0;
                end else begin
                    next_s[4*i +: 4] = nib_s + 4'd1;
                    carry_s          = 1'b0;
                end
            end else if (carry_s) begin
                if (nib_s == 4'd0) begin
                    next_s[4*i +: 4] = LIM;
                end else begin
                    next_s[4*i +: 4] = nib_s - 4'd1;
                    carry_s          = 1'b0;
                end
            end else begin
                next_s[4*i +: 4] = nib_s;
            end
        end
    end

    // Counter state: clear wins, opposing inc/dec cancel out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_r <= '0;
            wrap_r   <= 1'b0;
        end else if (en && clr) begin
            digits_r <= '0;
            wrap_r   <= 1'b0;
        end else if (en && (inc ^ dec)) begin
            digits_r <= next_s;
            wrap_r   <= carry_s;
        end else begin
            wrap_r   <= 1'b0;
        end
    end

    assign digits = digits_r;
    assign wrap   = wrap_r;

endmodule

// File: rtl/multi_counter_display.sv
// Bank of press counters sharing one multiplexed seven-segment display, with
// manual or timed channel selection.
module multi_counter_display
    import mcd_pkg::*;
#(
    parameter int NUM_COUNTERS = 4,
    parameter int NUM_SEGMENTS = 4,
    parameter logic [NUM_COUNTERS-1:0] MODE_MASK = 4'b1010,
    parameter int CLK_PER      = 10,
    parameter int REFR_RATE    = 1000,
    parameter int DWELL_US     = 1_000_000,
    localparam int CH_W        = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1,
    localparam int ND          = NUM_SEGMENTS - 1
) (
    input  logic                    clk,
    input  logic                    CPU_RESETN,
    input  logic                    btn_inc,
    input  logic                    btn_dec,
    input  logic                    btn_clr,
    input  logic                    btn_sel,
    input  logic                    auto_scan,
    output logic [CH_W-1:0]         sel_ch,
    output logic [4*ND-1:0]         value_sel,
    output logic [NUM_COUNTERS-1:0] wrap,
    output logic [NUM_SEGMENTS-1:0] anode,
    output logic [7:0]              cathode
);

    localparam int DIGIT_CYC = calc_digit_cyc(CLK_PER, REFR_RATE);
    localparam int DWELL_CYC = calc_dwell_cyc(DWELL_US, CLK_PER);
    localparam int TW  = (DIGIT_CYC > 1) ? $clog2(DIGIT_CYC) : 1;
    localparam int DWW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    localparam int DW  = $clog2(NUM_SEGMENTS);

    logic [CH_W-1:0] sel_r;
    logic [CH_W-1:0] sel_next_s;
    logic [DWW-1:0]  dwell_r;
    logic [4*ND-1:0] ch_digits_s [NUM_COUNTERS];
    logic [DW-1:0]   dig_r;
    logic [TW-1:0]   tmr_r;
    logic [3:0]      cur_nib_s;
    logic            cur_dp_s;
    logic [NUM_SEGMENTS-1:0] anode_r;
    logic [7:0]      cathode_r;

    assign sel_next_s = (sel_r == CH_W'(NUM_COUNTERS - 1)) ? '0 : sel_r + CH_W'(1);

    // Channel selection: manual step restarts the dwell, auto-scan steps on expiry
    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            sel_r   <= '0;
            dwell_r <= '0;
        end else if (btn_sel) begin
            sel_r   <= sel_next_s;
            dwell_r <= '0;
        end else if (!auto_scan) begin
            dwell_r <= '0;
        end else if (dwell_r == DWW'(DWELL_CYC - 1)) begin
            sel_r   <= sel_next_s;
            dwell_r <= '0;
        end else begin
            dwell_r <= dwell_r + DWW'(1);
        end
    end

    for (genvar g = 0; g < NUM_COUNTERS; g++) begin : g_ch
        mcd_channel #(
            .ND     (ND),
            .IS_DEC (MODE_MASK[g])
        ) u_ch (
            .clk    (clk),
            .rst_n  (CPU_RESETN),
            .en     (sel_r == CH_W'(g)),
            .inc    (btn_inc),
            .dec    (btn_dec),
            .clr    (btn_clr),
            .digits (ch_digits_s[g]),
            .wrap   (wrap[g])
        );
    end

    assign sel_ch    = sel_r;
    assign value_sel = ch_digits_s[sel_r];

    // Leftmost digit shows the channel index with DP lit; others show the value
    always_comb begin
        cur_nib_s = 4'(sel_r);
        cur_dp_s  = 1'b1;
        for (int i = 0; i < ND; i++) begin
            if (dig_r == DW'(i)) begin
                cur_nib_s = value_sel[4*i +: 4];
                cur_dp_s  = 1'b0;
            end else begin
                cur_nib_s = cur_nib_s;
                cur_dp_s  = cur_dp_s;
            end
        end
    end

    // Display scanner: registered anode/cathode, digit advances every DIGIT_CYC
    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            dig_r     <= '0;
            tmr_r     <= '0;
            anode_r   <= '1;
            cathode_r <= 8'hFF;
        end else begin
            anode_r   <= ~(NUM_SEGMENTS'(1) << dig_r);
            cathode_r <= seg_encode(cur_nib_s, cur_dp_s);
            if (tmr_r == TW'(DIGIT_CYC - 1)) begin
                tmr_r <= '0;
                dig_r <= (dig_r == DW'(NUM_SEGMENTS - 1)) ? '0 : dig_r + DW'(1);
            end else begin
                tmr_r <= tmr_r + TW'(1);
            end
        end
    end

    assign anode   = anode_r;
    assign cathode = cathode_r;

endmodule

// File: tb/tb_multi_counter_display.sv
// Self-checking bench for multi_counter_display: directed scenarios plus
// randomized commands against an integer-arithmetic reference model.
module tb_multi_counter_display;

    localparam int NC = 4;
    localparam logic [3:0] MASK = 4'b1010;

    logic        clk = 1'b0;
    logic        CPU_RESETN;
    logic        btn_inc, btn_dec, btn_clr, btn_sel, auto_scan;
    logic [1:0]  sel_ch;
    logic [11:0] value_sel;
    logic [3:0]  wrap;
    logic [3:0]  anode;
    logic [7:0]  cathode;

    int checks = 0;
    int errors = 0;
    int mval [NC];
    int msel;
    logic [3:0] mwrap;

    multi_counter_display #(
        .NUM_COUNTERS (4),
        .NUM_SEGMENTS (4),
        .MODE_MASK    (4'b1010),
        .CLK_PER      (10),
        .REFR_RATE    (25_000_000),
        .DWELL_US     (1)
    ) dut (
        .clk        (clk),
        .CPU_RESETN (CPU_RESETN),
        .btn_inc    (btn_inc),
        .btn_dec    (btn_dec),
        .btn_clr    (btn_clr),
        .btn_sel    (btn_sel),
        .auto_scan  (auto_scan),
        .sel_ch     (sel_ch),
        .value_sel  (value_sel),
        .wrap       (wrap),
        .anode      (anode),
        .cathode    (cathode)
    );

    always #5 clk = ~clk;

    function automatic int modulus(input int ch);
        return MASK[ch] ? 1000 : 4096;
    endfunction

    function automatic logic [11:0] to_digits(input int ch, input int v);
        if (MASK[ch]) return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
        else return 12'(v);
    endfunction

    function automatic logic [7:0] glyph(input int code, input bit dp);
        logic [6:0] s;
        case (code)
            0: s = 7'h40;  1: s = 7'h79;  2: s = 7'h24;  3: s = 7'h30;
            4: s = 7'h19;  5: s = 7'h12;  6: s = 7'h02;  7: s = 7'h78;
            8: s = 7'h00;  9: s = 7'h10; 10: s = 7'h08; 11: s = 7'h03;
           12: s = 7'h46; 13: s = 7'h21; 14: s = 7'h06; 15: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return {~dp, s};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NC; i++) mval[i] = 0;
        msel  = 0;
        mwrap = 4'b0000;
    endfunction

    // One-cycle pulse of the given buttons; returns at the following negedge
    task automatic cmd(input bit i, input bit d, input bit c, input bit s);
        int ch;
        @(negedge clk);
        btn_inc = i; btn_dec = d; btn_clr = c; btn_sel = s;
        @(negedge clk);
        btn_inc = 1'b0; btn_dec = 1'b0; btn_clr = 1'b0; btn_sel = 1'b0;
        ch = msel;
        mwrap = 4'b0000;
        if (c) begin
            mval[ch] = 0;
        end else if (i && !d) begin
            if (mval[ch] == modulus(ch) - 1) begin mval[ch] = 0; mwrap[ch] = 1'b1; end
            else mval[ch] = mval[ch] + 1;
        end else if (d && !i) begin
            if (mval[ch] == 0) begin mval[ch] = modulus(ch) - 1; mwrap[ch] = 1'b1; end
            else mval[ch] = mval[ch] - 1;
        end
        if (s) msel = (msel + 1) % NC;
    endtask

    task automatic goto_ch(input int target);
        while (msel != target) cmd(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        CPU_RESETN = 1'b0;
        btn_inc = 1'b0; btn_dec = 1'b0; btn_clr = 1'b0; btn_sel = 1'b0; auto_scan = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        CPU_RESETN = 1'b1;
        checks++;
        if (sel_ch !== 2'd0 || value_sel !== 12'h000 || wrap !== 4'h0 ||
            anode !== 4'hF || cathode !== 8'hFF) begin
            errors++;
            $display("FAIL reset_values sel=%0d val=%h wrap=%b an=%b cat=%h required 0 000 0000 1111 ff",
                     sel_ch, value_sel, wrap, anode, cathode);
        end
        @(negedge clk);
        checks++;
        if (anode !== 4'b1110 || cathode !== glyph(0, 1'b0)) begin
            errors++;
            $display("FAIL first_anode an=%b cat=%h required 1110 %h", anode, cathode, glyph(0, 1'b0));
        end
    endtask

    task automatic test_hex();
        goto_ch(0);
        repeat (255) cmd(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (value_sel !== 12'h0FF) begin
            errors++; $display("FAIL hex_load value=%h required 0ff", value_sel);
        end
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (value_sel !== 12'h100 || wrap !== 4'b0000) begin
            errors++; $display("FAIL hex_carry value=%h wrap=%b required 100 0000", value_sel, wrap);
        end
        cmd(1'b0, 1'b0, 1'b1, 1'b0);
        cmd(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (value_sel !== 12'hFFF || wrap !== 4'b0001) begin
            errors++; $display("FAIL hex_down_wrap value=%h wrap=%b required fff 0001", value_sel, wrap);
        end
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (value_sel !== 12'h000 || wrap !== 4'b0001) begin
            errors++; $display("FAIL hex_up_wrap value=%h wrap=%b required 000 0001", value_sel, wrap);
        end
        @(negedge clk);
        checks++;
        if (wrap !== 4'b0000) begin
            errors++; $display("FAIL hex_wrap_single wrap=%b required 0000", wrap);
        end
    endtask

    task automatic test_dec();
        cmd(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (sel_ch !== 2'd1) begin
            errors++; $display("FAIL dec_select sel=%0d required 1", sel_ch);
        end
        repeat (10) cmd(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (value_sel !== 12'h010) begin
            errors++; $display("FAIL dec_ten value=%h required 010", value_sel);
        end
        cmd(1'b0, 1'b0, 1'b1, 1'b0);
        cmd(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (value_sel !== 12'h999 || wrap !== 4'b0010) begin
            errors++; $display("FAIL dec_down_wrap value=%h wrap=%b required 999 0010", value_sel, wrap);
        end
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (value_sel !== 12'h000 || wrap !== 4'b0010) begin
            errors++; $display("FAIL dec_up_wrap value=%h wrap=%b required 000 0010", value_sel, wrap);
        end
    endtask

    task automatic test_combo();
        cmd(1'b0, 1'b1, 1'b0, 1'b0);
        cmd(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (value_sel !== 12'h999 || wrap !== 4'b0000) begin
            errors++; $display("FAIL inc_dec_cancel value=%h wrap=%b required 999 0000", value_sel, wrap);
        end
        cmd(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (value_sel !== 12'h000 || wrap !== 4'b0000) begin
            errors++; $display("FAIL clr_priority value=%h wrap=%b required 000 0000", value_sel, wrap);
        end
        // A command together with btn_sel lands on the channel being left
        cmd(1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (sel_ch !== 2'd2 || mval[1] != 1 || value_sel !== to_digits(2, mval[2])) begin
            errors++; $display("FAIL cmd_with_sel sel=%0d value=%h required 2 %h", sel_ch, value_sel, to_digits(2, mval[2]));
        end
    endtask

    task automatic test_random();
        bit i, d, c, s;
        for (int n = 0; n < 300; n++) begin
            i = ($urandom_range(0, 2) != 0);
            d = ($urandom_range(0, 3) == 0);
            c = ($urandom_range(0, 15) == 0);
            s = ($urandom_range(0, 7) == 0);
            cmd(i, d, c, s);
            checks++;
            if (sel_ch !== 2'(msel) || value_sel !== to_digits(msel, mval[msel]) || wrap !== mwrap) begin
                errors++;
                $display("FAIL random_%0d sel=%0d val=%h wrap=%b required %0d %h %b",
                         n, sel_ch, value_sel, wrap, msel, to_digits(msel, mval[msel]), mwrap);
            end
        end
    endtask

    task automatic test_scanner();
        logic [3:0] prev;
        bit found;
        logic [7:0] exp_cat;
        int code;
        goto_ch(2);
        cmd(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (165) cmd(1'b1, 1'b0, 1'b0, 1'b0);
        found = 1'b0;
        prev = anode;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (anode === 4'b1110 && prev === 4'b0111) found = 1'b1;
            prev = anode;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL scan_align anode=%b required 1110 after 0111 within 40 cycles", anode);
        end
        for (int k = 0; k < 16; k++) begin
            case (k / 4)
                0: code = 5;
                1: code = 10;
                2: code = 0;
                default: code = 2;
            endcase
            exp_cat = glyph(code, (k / 4) == 3);
            checks++;
            if (anode !== ~(4'b0001 << (k / 4)) || cathode !== exp_cat) begin
                errors++;
                $display("FAIL scan_cycle_%0d an=%b cat=%h required %b %h",
                         k, anode, cathode, ~(4'b0001 << (k / 4)), exp_cat);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_autoscan();
        int exp_sel;
        goto_ch(0);
        auto_scan = 1'b1;
        for (int n = 1; n <= 450; n++) begin
            @(negedge clk);
            exp_sel = (n / 100) % NC;
            checks++;
            if (sel_ch !== 2'(exp_sel) || value_sel !== to_digits(exp_sel, mval[exp_sel])) begin
                errors++; $display("FAIL autoscan_%0d sel=%0d required %0d", n, sel_ch, exp_sel);
            end
        end
        auto_scan = 1'b0;
        msel = 0;
        repeat (150) @(negedge clk);
        checks++;
        if (sel_ch !== 2'd0) begin
            errors++; $display("FAIL autoscan_hold sel=%0d required 0", sel_ch);
        end
        auto_scan = 1'b1;
        for (int n = 1; n <= 260; n++) begin
            btn_sel = (n == 50);
            @(negedge clk);
            btn_sel = 1'b0;
            exp_sel = (n < 50) ? 0 : (1 + (n - 50) / 100) % NC;
            checks++;
            if (sel_ch !== 2'(exp_sel)) begin
                errors++; $display("FAIL autoscan_restart_%0d sel=%0d required %0d", n, sel_ch, exp_sel);
            end
        end
        auto_scan = 1'b0;
        msel = 3;
    endtask

    task automatic test_reset_mid();
        auto_scan = 1'b1;
        repeat (3) cmd(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        CPU_RESETN = 1'b0;
        #1;
        checks++;
        if (sel_ch !== 2'd0 || value_sel !== 12'h000 || wrap !== 4'h0 ||
            anode !== 4'hF || cathode !== 8'hFF) begin
            errors++;
            $display("FAIL reset_mid sel=%0d val=%h wrap=%b an=%b cat=%h required 0 000 0000 1111 ff",
                     sel_ch, value_sel, wrap, anode, cathode);
        end
        auto_scan = 1'b0;
        model_reset();
        @(negedge clk);
        CPU_RESETN = 1'b1;
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (sel_ch !== 2'd0 || value_sel !== 12'h001) begin
            errors++; $display("FAIL reset_resume sel=%0d val=%h required 0 001", sel_ch, value_sel);
        end
    endtask

    initial begin
        test_reset();
        test_hex();
        test_dec();
        test_combo();
        test_random();
        test_scanner();
        test_autoscan();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_counter_display.md
# multi_counter_display

Bank of NUM_COUNTERS independent press counters, each HEX or BCD, sharing one multiplexed seven-segment display. Debounced single-cycle button pulses increment, decrement or clear the selected channel, or step the selection. The leftmost digit shows the channel index; the remaining digits show that channel's value. An optional auto-scan mode rotates the displayed channel on a fixed dwell time. The block sits after the reset cleaner and button debouncers, replacing per-display counter/seven-segment pairs.

## Interface
- NUM_COUNTERS, 4, channel count, 2..16; CH_W = max(1, $clog2(NUM_COUNTERS)).
- NUM_SEGMENTS, 4, digits on the display, 2..8; value digits ND = NUM_SEGMENTS-1.
- MODE_MASK, 'b1010, NUM_COUNTERS bits; bit i = 1 makes channel i decimal (BCD), 0 makes it HEX.
- CLK_PER, 10, clock period in ns.
- REFR_RATE, 1000, digit step rate in Hz; DIGIT_CYC = 1e9/(CLK_PER*REFR_RATE), minimum 1.
- DWELL_US, 1_000_000, auto-scan dwell in µs; DWELL_CYC = DWELL_US*1000/CLK_PER.

Ports:
- clk  in  1  system clock; the single clock domain.
- CPU_RESETN  in  1  asynchronous, active-low reset.
- btn_inc  in  1  one-cycle pulse: increment the selected channel.
- btn_dec  in  1  one-cycle pulse: decrement the selected channel.
- btn_clr  in  1  one-cycle pulse: clear the selected channel.
- btn_sel  in  1  one-cycle pulse: select the next channel.
- auto_scan  in  1  level; 1 enables automatic channel rotation.
- sel_ch  out  CH_W  currently selected channel.
- value_sel  out  4*ND  digit vector of the selected channel; digit 0 is least significant.
- wrap  out  NUM_COUNTERS  one-cycle pulse per channel on wrap-around.
- anode  out  NUM_SEGMENTS  active-low, one-cold digit enable; bit 0 is the rightmost digit.
- cathode  out  8  active-low; [6:0] = {g,f,e,d,c,b,a}, [7] = decimal point.

## Operation
- Reset values: all counters 0, sel_ch 0, wrap 0, value_sel 0, anode all 1, cathode all 1 (blank), scan digit 0, dwell and refresh timers 0.
- Command priority on the selected channel: btn_clr > (btn_inc XOR btn_dec). If btn_inc and btn_dec arrive together, the value does not change and no wrap pulse is produced.
- HEX channel: ND-nibble binary count. Up from all-F wraps to 0; down from 0 wraps to all-F.
- DEC channel: digit-wise BCD with ripple carry/borrow. Up from all-9 wraps to 0; down from 0 wraps to all-9. Digits are always in the range 0..9.
- wrap[i] pulses for exactly the cycle after the wrapping update. Clear never produces a wrap pulse.
- Channel selection: btn_sel advances sel_ch by 1, modulo NUM_COUNTERS. A command pulse in the same cycle as btn_sel applies to the old channel.
- Auto-scan: while auto_scan = 1, the dwell counter advances sel_ch every DWELL_CYC cycles. btn_sel also advances sel_ch and restarts the dwell counter. Deasserting auto_scan holds sel_ch and zeroes the dwell counter.
- Display scanner: the active digit d cycles 0..NUM_SEGMENTS-1, advancing every DIGIT_CYC cycles. For d < ND, the digit shows value_sel digit d with DP off. For d = NUM_SEGMENTS-1, it shows sel_ch as a hex glyph with DP on. Leading zeros are displayed.
- Glyphs: standard 0-9 and A-F (b, d lowercase). Codes outside 0..F blank the digit.

## Timing
- A pulse sampled at edge n updates the counter and value_sel at edge n+1. wrap is also asserted at edge n+1.
- A btn_sel or dwell-expiry at edge n updates sel_ch and value_sel at edge n+1.
- anode and cathode are registered and change on the same edge. Cathode reflects value_sel sampled one cycle earlier, so display latency is at most 2 cycles after a value change, and a value change becomes visible within 1 cycle once its digit is active.
- First anode assertion (anode = ~1) occurs on the first edge after reset release.
- Asynchronous reset mid-operation immediately forces all reset values, including blanking the display.

## Structure
- Package mcd_pkg holds the glyph function seg_encode(nibble, dp) returning the 8-bit cathode value, the MODE_HEX/MODE_DEC localparams, and the DIGIT_CYC and DWELL_CYC derivation functions.
- Sub-module mcd_channel holds one channel: it takes parameter IS_DEC, inputs inc/dec/clr/en, and outputs the digits and wrap. It is instantiated NUM_COUNTERS times in a generate loop.
- The top level contains the selection/dwell logic, the output mux, and the scanner.

## Test plan
- Bench parameters: defaults except REFR_RATE = 25_000_000 (DIGIT_CYC = 4) and DWELL_US = 1 (DWELL_CYC = 100).
- Channel 0 (HEX), 0x0FF, one btn_inc -> 0x100, wrap = 0. At 0xFFF, one btn_inc -> 0x000 and a single-cycle wrap[0].
- Channel 1 (DEC): btn_sel, then 10 btn_inc -> value_sel 0x010. At 0x000, one btn_dec -> 0x999 and wrap[1].
- Simultaneous btn_inc + btn_dec -> value unchanged. btn_clr + btn_inc -> value 0, no wrap.
- auto_scan = 1 for 450 cycles -> sel_ch steps 0->1->2->3->0. A btn_sel at cycle 50 restarts the dwell count.
- Scanner with sel_ch = 2 holding 0x0A5: over 16 cycles, anode walks 1110, 1101, 1011, 0111 with 4 cycles each. Cathode shows 5, A, 0, then "2" with DP low.
- Assert CPU_RESETN low mid-count with auto_scan active -> all outputs at reset values in the same cycle. Counting resumes from 0 after release.
